// File: rtl/knn_topk_select_pkg.sv
// Shared types for the k-nearest-neighbour top-K selector: FSM states and the
// sorted-list entry. Entry widths are fixed here and must match the top parameters.
package knn_pkg;

  localparam int KNN_SIZE  = 32;
  localparam int KNN_CLSTR = 2;
  localparam int KNN_K     = 3;
  localparam int KNN_IDX_W = 8;

  typedef enum logic [1:0] {IDLE, ACCEPT, INSERT, DONE} knn_state_t;

  typedef struct packed {
    logic                 vld;
    logic [KNN_SIZE-1:0]  dst;
    logic [KNN_IDX_W-1:0] idx;
  } knn_entry_t;

endpackage

// File: rtl/knn_topk_select_if.sv
// Beat stream from the cluster distance stage: CLSTR_SIZE distances per
// handshake, tagged with the point index of lane 0.
interface knn_topk_select_if
  import knn_pkg::*;
#(
  parameter int SIZE       = KNN_SIZE,
  parameter int CLSTR_SIZE = KNN_CLSTR,
  parameter int IDX_W      = KNN_IDX_W
);
  logic                             in_valid;
  logic                             in_ready;
  logic [CLSTR_SIZE-1:0][SIZE-1:0]  in_dst;
  logic [IDX_W-1:0]                 in_base_idx;
  logic                             in_last;

  modport master (output in_valid, in_dst, in_base_idx, in_last, input in_ready);
  modport slave  (input in_valid, in_dst, in_base_idx, in_last, output in_ready);
endinterface

// File: rtl/knn_topk_select_slot.sv
// One position of the sorted top-K list: decides whether the candidate lands
// here and selects hold / candidate / shifted-in neighbour for the next value.
module knn_topk_slot
  import knn_pkg::*;
(
  input  logic       ins,
  input  logic       take_prev,
  input  knn_entry_t cand,
  input  knn_entry_t cur,
  input  knn_entry_t prev,
  output logic       take,
  output knn_entry_t nxt
);

  // Strict compare keeps an earlier-arriving equal distance ahead of the candidate.
  always_comb begin
    take = ins && (!cur.vld || (cand.dst < cur.dst));
    nxt  = cur;
    if (take_prev) begin
      nxt = prev;
    end else if (take) begin
      nxt = cand;
    end
  end

endmodule

// File: rtl/knn_topk_select.sv
// Running top-K (smallest distance) selector: accepts beats of CLSTR_SIZE
// distances, inserts one lane per cycle into a sorted list, holds the result.
module knn_topk_select
  import knn_pkg::*;
#(
  parameter int SIZE       = KNN_SIZE,
  parameter int CLSTR_SIZE = KNN_CLSTR,
  parameter int K          = KNN_K,
  parameter int IDX_W      = KNN_IDX_W
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  knn_topk_select_if.slave             bus,
  output logic [K-1:0][SIZE-1:0]       knn_dst,
  output logic [K-1:0][IDX_W-1:0]      knn_idx,
  output logic [$clog2(K+1)-1:0]       knn_cnt,
  output logic                         done
);

  localparam int LANE_W = (CLSTR_SIZE > 1) ? $clog2(CLSTR_SIZE) : 1;
  localparam int CNT_W  = $clog2(K+1);

  knn_state_t                       state, state_nxt;
  logic [LANE_W-1:0]                lane;
  logic [CLSTR_SIZE-1:0][SIZE-1:0]  hold_dst;
  logic [IDX_W-1:0]                 hold_base;
  logic                             hold_last;
  logic                             load, ins, clr;
  logic [CNT_W-1:0]                 cnt;
  knn_entry_t                       cand;
  knn_entry_t                       ent     [K];
  knn_entry_t                       ent_nxt [K];
  logic [K-1:0]                     take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        lane <= '0;
      end else if (ins) begin
        lane <= lane + 1'b1;
      end
    end
  end

  // start overrides any handshake or insert pending in the same cycle
  always_comb begin
    state_nxt    = state;
    bus.in_ready = (state == ACCEPT);
    done         = (state == DONE);
    load         = 1'b0;
    ins          = 1'b0;
    clr          = 1'b0;
    if (start) begin
      clr       = 1'b1;
      state_nxt = ACCEPT;
    end else begin
      case (state)
        IDLE: begin
        end
        ACCEPT: begin
          if (bus.in_valid) begin
            load      = 1'b1;
            state_nxt = INSERT;
          end
        end
        INSERT: begin
          ins = 1'b1;
          if (lane == LANE_W'(CLSTR_SIZE - 1)) begin
            state_nxt = hold_last ? DONE : ACCEPT;
          end
        end
        DONE: begin
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      hold_dst  <= bus.in_dst;
      hold_base <= bus.in_base_idx;
      hold_last <= bus.in_last;
    end
  end

  // Point index wraps modulo 2^IDX_W.
  always_comb begin
    cand     = '0;
    cand.vld = 1'b1;
    cand.dst = hold_dst[lane];
    cand.idx = hold_base + IDX_W'(lane);
  end

  for (genvar j = 0; j < K; j++) begin : g_slot
    knn_entry_t prev_e;
    logic       take_prev;
    if (j == 0) begin : g_head
      assign prev_e    = cand;
      assign take_prev = 1'b0;
    end else begin : g_body
      assign prev_e    = ent[j-1];
      assign take_prev = take[j-1];
    end

    knn_topk_slot u_slot (
      .ins       (ins),
      .take_prev (take_prev),
      .cand      (cand),
      .cur       (ent[j]),
      .prev      (prev_e),
      .take      (take[j]),
      .nxt       (ent_nxt[j])
    );

    assign knn_dst[j] = ent[j].dst;
    assign knn_idx[j] = ent[j].idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < K; j++) ent[j] <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int j = 0; j < K; j++) ent[j] <= '{vld: 1'b0, dst: '1, idx: '0};
      cnt <= '0;
    end else if (ins) begin
      for (int j = 0; j < K; j++) ent[j] <= ent_nxt[j];
      if (cnt != CNT_W'(K)) cnt <= cnt + 1'b1;
    end
  end

  assign knn_cnt = cnt;

endmodule

// File: tb/tb_knn_topk_select.sv
// Bench for knn_topk_select: directed and random queries, scoreboard checked
// by a done-edge monitor against a stable-sort reference of all candidates.
module tb_knn_topk_select;

  typedef struct packed {
    logic [2:0][31:0] dst;
    logic [2:0][7:0]  idx;
    logic [1:0]       cnt;
  } exp_t;

  logic             clk, rst, start, done;
  logic [2:0][31:0] knn_dst;
  logic [2:0][7:0]  knn_idx;
  logic [1:0]       knn_cnt;

  int          total = 0;
  int          bad   = 0;
  int          hs_cnt = 0;
  time         last_hs_t = 0;
  logic        done_q = 1'b0;
  exp_t        sb [$];
  logic [31:0] cand_d [$];
  logic [7:0]  cand_i [$];
  logic [31:0] bd0 [8];
  logic [31:0] bd1 [8];
  logic [7:0]  bbase [8];

  knn_topk_select_if #(.SIZE(32), .CLSTR_SIZE(2), .IDX_W(8)) bus ();

  knn_topk_select #(.SIZE(32), .CLSTR_SIZE(2), .K(3), .IDX_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .knn_dst (knn_dst),
    .knn_idx (knn_idx),
    .knn_cnt (knn_cnt),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && !start && bus.in_valid && bus.in_ready) hs_cnt++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: K smallest distances, ties ordered by arrival; unfilled slots all-ones/0.
  function automatic exp_t model();
    exp_t e;
    bit   used [64];
    int   n = cand_d.size();
    for (int m = 0; m < 64; m++) used[m] = 1'b0;
    e.cnt = (n < 3) ? 2'(n) : 2'd3;
    for (int k = 0; k < 3; k++) begin
      int best = -1;
      e.dst[k] = 32'hFFFF_FFFF;
      e.idx[k] = 8'd0;
      for (int m = 0; m < n; m++)
        if (!used[m] && (best < 0 || cand_d[m] < cand_d[best])) best = m;
      if (best >= 0) begin
        used[best] = 1'b1;
        e.dst[k] = cand_d[best];
        e.idx[k] = cand_i[best];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_knn_dst", knn_dst, e.dst);
          chk("sb_knn_idx", knn_idx, e.idx);
          chk("sb_knn_cnt", knn_cnt, e.cnt);
        end
      end
      done_q = done;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cand_d.delete();
    cand_i.delete();
  endtask

  // Holds in_valid high; scrambles the beat fields while in_ready is low.
  task automatic send_beat(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [7:0] base, input logic last, input bit first);
    int  w = 0;
    time hs_t;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 20) begin
      bus.in_dst      = {$urandom, $urandom};
      bus.in_base_idx = 8'($urandom);
      bus.in_last     = 1'($urandom);
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", bus.in_ready, 1'b1);
    end else begin
      bus.in_dst      = {d1, d0};
      bus.in_base_idx = base;
      bus.in_last     = last;
      @(posedge clk);
      hs_t = $time;
      if (!first) chk("hs_spacing", 128'(hs_t - last_hs_t), 128'd30);
      last_hs_t = hs_t;
      cand_d.push_back(d0);
      cand_i.push_back(base);
      cand_d.push_back(d1);
      cand_i.push_back(8'(base + 8'd1));
      @(negedge clk);
    end
  endtask

  task automatic run_query(input int nb);
    int w = 0;
    int hs0;
    do_start();
    hs0 = hs_cnt;
    for (int b = 0; b < nb; b++) send_beat(bd0[b], bd1[b], bbase[b], b == nb - 1, b == 0);
    bus.in_valid = 1'b0;
    sb.push_back(model());
    while (!done && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done, 1'b1);
    chk("hs_count", 128'(hs_cnt - hs0), 128'(nb));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dst = '0;
    bus.in_base_idx = '0;
    bus.in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", knn_cnt, 2'd0);
    chk("rst_dst", knn_dst, 96'd0);
    chk("rst_idx", knn_idx, 24'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b0);

    // single beat, list not full
    bd0[0] = 32'd5; bd1[0] = 32'd9; bbase[0] = 8'd0;
    run_query(1);
    chk("t1_dst", knn_dst, {32'hFFFF_FFFF, 32'd9, 32'd5});
    chk("t1_idx", knn_idx, {8'd0, 8'd1, 8'd0});
    chk("t1_cnt", knn_cnt, 2'd2);

    // three beats, later equal distance dropped
    bd0[0] = 32'd7; bd1[0] = 32'd3; bbase[0] = 8'd0;
    bd0[1] = 32'd8; bd1[1] = 32'd1; bbase[1] = 8'd2;
    bd0[2] = 32'd3; bd1[2] = 32'd2; bbase[2] = 8'd4;
    run_query(3);
    chk("t2_dst", knn_dst, {32'd3, 32'd2, 32'd1});
    chk("t2_idx", knn_idx, {8'd1, 8'd5, 8'd3});
    chk("t2_cnt", knn_cnt, 2'd3);

    // all ties
    bd0[0] = 32'd4; bd1[0] = 32'd4; bbase[0] = 8'd0;
    bd0[1] = 32'd4; bd1[1] = 32'd4; bbase[1] = 8'd2;
    run_query(2);
    chk("t3_idx", knn_idx, {8'd2, 8'd1, 8'd0});

    // index wrap
    bd0[0] = 32'd2; bd1[0] = 32'd1; bbase[0] = 8'd255;
    run_query(1);
    chk("t5_dst", knn_dst[1:0], {32'd2, 32'd1});
    chk("t5_idx", knn_idx[1:0], {8'd255, 8'd0});

    // all-ones distance while not full
    bd0[0] = 32'hFFFF_FFFF; bd1[0] = 32'd6; bbase[0] = 8'd40;
    run_query(1);
    chk("ones_idx", knn_idx, {8'd0, 8'd40, 8'd41});
    chk("ones_cnt", knn_cnt, 2'd2);

    // start mid-INSERT aborts the query
    do_start();
    send_beat(32'd10, 32'd20, 8'd0, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_cnt", knn_cnt, 2'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_cnt", knn_cnt, 2'd0);
    chk("abort_dst", knn_dst, {96{1'b1}});
    chk("abort_idx", knn_idx, 24'd0);
    chk("abort_done", done, 1'b0);

    // rst mid-INSERT
    do_start();
    send_beat(32'd10, 32'd20, 8'd7, 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_cnt", knn_cnt, 2'd0);
    chk("rstmid_dst", knn_dst, 96'd0);
    chk("rstmid_idx", knn_idx, 24'd0);
    chk("rstmid_in_ready", bus.in_ready, 1'b0);
    chk("rstmid_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_idle_done", done, 1'b0);
    chk("rstmid_idle_ready", bus.in_ready, 1'b0);

    // random queries
    for (int q = 0; q < 25; q++) begin
      int nb = $urandom_range(1, 5);
      int mode = $urandom_range(0, 2);
      logic [7:0] base = 8'($urandom);
      for (int b = 0; b < nb; b++) begin
        bbase[b] = 8'(base + 8'(2 * b));
        case (mode)
          0: begin bd0[b] = 32'($urandom_range(0, 7)); bd1[b] = 32'($urandom_range(0, 7)); end
          1: begin bd0[b] = $urandom; bd1[b] = $urandom; end
          default: begin
            bd0[b] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 100));
            bd1[b] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 100));
          end
        endcase
      end
      run_query(nb);
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
